// File: rtl/reg_file_sb_if.sv
// ============================================================================
// reg_file_sb_if : writeback, read-operand and issue signals of reg_file_sb
// Rev 1.0
// ============================================================================
`default_nettype none

interface reg_file_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_err;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output wr_en, rd_addr, rd_data, rs1_addr, rs2_addr, iss_en, iss_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_err, busy_cnt
    );

    modport slave (
        input  wr_en, rd_addr, rd_data, rs1_addr, rs2_addr, iss_en, iss_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_err, busy_cnt
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// reg_file_sb : integer register file with writeback bypass and busy scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_sb #(
    parameter int          XLEN    = 32,
    parameter int          ADDR_W  = 5,
    parameter int          SP_IDX  = 2,
    parameter int unsigned SP_INIT = 4096,
    parameter int          BYPASS  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int NREGS     = 2 ** ADDR_W;
    localparam int CNT_W     = ADDR_W + 1;
    localparam bit BYPASS_ON = (BYPASS != 0);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CNT_W-1:0] r_busy_cnt;

    logic             w_clr;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;
    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic [NREGS-1:0] w_busy_nxt;

    assign w_clr = bus.wr_en  && (bus.rd_addr  != '0);
    assign w_set = bus.iss_en && (bus.iss_addr != '0);

    // A new producer on the written address keeps the bit set, so no decrement.
    assign w_inc = w_set && !r_busy[bus.iss_addr];
    assign w_dec = w_clr && r_busy[bus.rd_addr] && !(w_set && (bus.iss_addr == bus.rd_addr));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) w_busy_nxt[bus.rd_addr]  = 1'b0;
        if (w_set) w_busy_nxt[bus.iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_clr) r_mem[bus.rd_addr] <= bus.rd_data;
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= r_busy_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
        end
    end

    assign w_rs1_hit = BYPASS_ON && bus.wr_en && (bus.rd_addr == bus.rs1_addr);
    assign w_rs2_hit = BYPASS_ON && bus.wr_en && (bus.rd_addr == bus.rs2_addr);

    assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                          w_rs1_hit ? bus.rd_data : r_mem[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                          w_rs2_hit ? bus.rd_data : r_mem[bus.rs2_addr];

    assign bus.rs1_busy = (bus.rs1_addr != '0) && r_busy[bus.rs1_addr] && !w_rs1_hit;
    assign bus.rs2_busy = (bus.rs2_addr != '0) && r_busy[bus.rs2_addr] && !w_rs2_hit;

    // WAW is advisory; a writeback landing on the same address hides it.
    assign bus.iss_err  = w_set && r_busy[bus.iss_addr] &&
                          !(bus.wr_en && (bus.rd_addr == bus.iss_addr));
    assign bus.busy_cnt = r_busy_cnt;
endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a BYPASS=1 and a BYPASS=0 instance driven in lockstep
// and compared against an array-based model of the register/busy rules.
`default_nettype none

module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en, iss_en;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr, iss_addr;
    logic [31:0] rd_data;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) bus_b ();
    reg_file_sb_if #(.XLEN(32), .ADDR_W(5)) bus_n ();

    assign bus_b.wr_en = wr_en;       assign bus_n.wr_en = wr_en;
    assign bus_b.rd_addr = rd_addr;   assign bus_n.rd_addr = rd_addr;
    assign bus_b.rd_data = rd_data;   assign bus_n.rd_data = rd_data;
    assign bus_b.rs1_addr = rs1_addr; assign bus_n.rs1_addr = rs1_addr;
    assign bus_b.rs2_addr = rs2_addr; assign bus_n.rs2_addr = rs2_addr;
    assign bus_b.iss_en = iss_en;     assign bus_n.iss_en = iss_en;
    assign bus_b.iss_addr = iss_addr; assign bus_n.iss_addr = iss_addr;

    reg_file_sb #(.BYPASS(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    reg_file_sb #(.BYPASS(0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = (i == 2) ? 32'd4096 : 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_data(bit byp, logic [4:0] a);
        if (a == 0) return 32'd0;
        if (byp && wr_en && rd_addr == a) return rd_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(bit byp, logic [4:0] a);
        if (a == 0) return 1'b0;
        if (byp && wr_en && rd_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_err();
        return iss_en && iss_addr != 0 && m_busy[iss_addr] && !(wr_en && rd_addr == iss_addr);
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += m_busy[i] ? 1 : 0;
        return 6'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (wr_en && rd_addr != 0) begin
                m_reg[rd_addr]  = rd_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 0; iss_en = 0; rd_addr = 0; iss_addr = 0; rd_data = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        wr_en = 1; rd_addr = 5; rd_data = 32'h55; iss_en = 1; iss_addr = 5;
        tick();
        rd_data = 32'h77; iss_addr = 6;
        #3 rst_n = 0;
        model_reset();
        wr_en = 0; rs1_addr = 2; rs2_addr = 5; iss_addr = 5;
        #1;
        n_checks += 6;
        if (bus_b.rs1_data !== 32'd4096) begin n_fail++; $display("FAIL reset_sp: got %h want %h", bus_b.rs1_data, 32'd4096); end
        if (bus_n.rs2_data !== 32'd0) begin n_fail++; $display("FAIL reset_x5: got %h want 0", bus_n.rs2_data); end
        if (bus_b.rs1_busy !== 1'b0 || bus_b.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", bus_b.rs1_busy, bus_b.rs2_busy); end
        if (bus_b.iss_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_b.iss_err); end
        if (bus_b.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt_b: got %0d want 0", bus_b.busy_cnt); end
        if (bus_n.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt_n: got %0d want 0", bus_n.busy_cnt); end
        wr_en = 1; rd_addr = 5;
        tick();
        wr_en = 0;
        #1;
        n_checks += 2;
        if (bus_b.rs2_data !== 32'd0) begin n_fail++; $display("FAIL reset_hold_data: got %h want 0", bus_b.rs2_data); end
        if (bus_b.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_hold_cnt: got %0d want 0", bus_b.busy_cnt); end
        iss_en = 0;
        #3 rst_n = 1;
    endtask

    task automatic test_write_x0();
        idle();
        wr_en = 1; rd_addr = 7; rd_data = 32'hDEADBEEF; tick();
        rd_addr = 0; tick();
        idle(); rs1_addr = 7; rs2_addr = 0; #1;
        n_checks += 3;
        if (bus_b.rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x7_b: got %h want deadbeef", bus_b.rs1_data); end
        if (bus_n.rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x7_n: got %h want deadbeef", bus_n.rs1_data); end
        if (bus_b.rs2_data !== 32'd0) begin n_fail++; $display("FAIL wr_x0: got %h want 0", bus_b.rs2_data); end
        iss_en = 1; iss_addr = 0; tick(); idle(); #1;
        n_checks += 1;
        if (bus_b.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL iss_x0_cnt: got %0d want 0", bus_b.busy_cnt); end
    endtask

    task automatic test_scoreboard();
        logic [31:0] old5;
        idle(); iss_en = 1; iss_addr = 5; tick();
        idle(); rs1_addr = 5; #1;
        n_checks += 3;
        if (bus_b.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy: got %b want 1", bus_b.rs1_busy); end
        if (bus_b.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_b: got %0d want 1", bus_b.busy_cnt); end
        if (bus_n.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL sb_cnt_n: got %0d want 1", bus_n.busy_cnt); end
        old5 = m_reg[5];
        wr_en = 1; rd_addr = 5; rd_data = 32'h1234; #1;
        n_checks += 4;
        if (bus_b.rs1_busy !== 1'b0 || bus_b.rs1_data !== 32'h1234) begin n_fail++; $display("FAIL sb_byp: got %b/%h want 0/1234", bus_b.rs1_busy, bus_b.rs1_data); end
        if (bus_n.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_nobyp_busy: got %b want 1", bus_n.rs1_busy); end
        if (bus_n.rs1_data !== old5) begin n_fail++; $display("FAIL sb_nobyp_data: got %h want %h", bus_n.rs1_data, old5); end
        if (bus_n.rs1_data !== exp_data(0, 5)) begin n_fail++; $display("FAIL sb_nobyp_model: got %h want %h", bus_n.rs1_data, exp_data(0, 5)); end
        tick(); idle(); #1;
        n_checks += 3;
        if (bus_n.rs1_data !== 32'h1234 || bus_n.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_after_n: got %b/%h want 0/1234", bus_n.rs1_busy, bus_n.rs1_data); end
        if (bus_b.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_after_cnt_b: got %0d want 0", bus_b.busy_cnt); end
        if (bus_n.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL sb_after_cnt_n: got %0d want 0", bus_n.busy_cnt); end
    endtask

    task automatic test_simul();
        idle(); iss_en = 1; iss_addr = 9; tick();
        wr_en = 1; rd_addr = 9; rd_data = 32'hAA; rs1_addr = 9; #1;
        n_checks += 2;
        if (bus_b.iss_err !== 1'b0) begin n_fail++; $display("FAIL simul_err_b: got %b want 0", bus_b.iss_err); end
        if (bus_n.iss_err !== 1'b0) begin n_fail++; $display("FAIL simul_err_n: got %b want 0", bus_n.iss_err); end
        tick(); idle(); #1;
        n_checks += 3;
        if (bus_b.rs1_data !== 32'hAA) begin n_fail++; $display("FAIL simul_data: got %h want aa", bus_b.rs1_data); end
        if (bus_b.rs1_busy !== 1'b1 || bus_n.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy: got %b%b want 11", bus_b.rs1_busy, bus_n.rs1_busy); end
        if (bus_b.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL simul_cnt: got %0d want 1", bus_b.busy_cnt); end
        wr_en = 1; rd_addr = 9; rd_data = 32'hAB; tick(); idle();
    endtask

    task automatic test_waw();
        idle(); iss_en = 1; iss_addr = 3; #1;
        n_checks += 1;
        if (bus_b.iss_err !== 1'b0) begin n_fail++; $display("FAIL waw_first: got %b want 0", bus_b.iss_err); end
        tick(); #1;
        n_checks += 1;
        if (bus_b.iss_err !== 1'b1 || bus_n.iss_err !== 1'b1) begin n_fail++; $display("FAIL waw_second: got %b%b want 11", bus_b.iss_err, bus_n.iss_err); end
        tick(); idle(); #1;
        n_checks += 1;
        if (bus_b.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_cnt: got %0d want 1", bus_b.busy_cnt); end
        iss_en = 1;
        for (int a = 1; a < 32; a++) begin iss_addr = 5'(a); tick(); end
        idle(); #1;
        n_checks += 2;
        if (bus_b.busy_cnt !== 6'd31) begin n_fail++; $display("FAIL sat_cnt_b: got %0d want 31", bus_b.busy_cnt); end
        if (bus_n.busy_cnt !== 6'd31) begin n_fail++; $display("FAIL sat_cnt_n: got %0d want 31", bus_n.busy_cnt); end
        wr_en = 1;
        for (int a = 1; a < 32; a++) begin rd_addr = 5'(a); rd_data = $urandom; tick(); end
        idle(); #1;
        n_checks += 1;
        if (bus_b.busy_cnt !== 6'd0 || bus_n.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL drain_cnt: got %0d/%0d want 0", bus_b.busy_cnt, bus_n.busy_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en    = ($urandom_range(0, 2) != 0);
            iss_en   = ($urandom_range(0, 1) != 0);
            rd_addr  = 5'($urandom_range(0, 31));
            iss_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            #1;
            n_checks += 8;
            if (bus_b.rs1_data !== exp_data(1, rs1_addr) || bus_b.rs2_data !== exp_data(1, rs2_addr)) begin n_fail++; $display("FAIL rnd_data_b: got %h/%h want %h/%h", bus_b.rs1_data, bus_b.rs2_data, exp_data(1, rs1_addr), exp_data(1, rs2_addr)); end
            if (bus_n.rs1_data !== exp_data(0, rs1_addr) || bus_n.rs2_data !== exp_data(0, rs2_addr)) begin n_fail++; $display("FAIL rnd_data_n: got %h/%h want %h/%h", bus_n.rs1_data, bus_n.rs2_data, exp_data(0, rs1_addr), exp_data(0, rs2_addr)); end
            if (bus_b.rs1_busy !== exp_busy(1, rs1_addr) || bus_b.rs2_busy !== exp_busy(1, rs2_addr)) begin n_fail++; $display("FAIL rnd_busy_b: got %b%b want %b%b", bus_b.rs1_busy, bus_b.rs2_busy, exp_busy(1, rs1_addr), exp_busy(1, rs2_addr)); end
            if (bus_n.rs1_busy !== exp_busy(0, rs1_addr) || bus_n.rs2_busy !== exp_busy(0, rs2_addr)) begin n_fail++; $display("FAIL rnd_busy_n: got %b%b want %b%b", bus_n.rs1_busy, bus_n.rs2_busy, exp_busy(0, rs1_addr), exp_busy(0, rs2_addr)); end
            if (bus_b.iss_err !== exp_err()) begin n_fail++; $display("FAIL rnd_err_b: got %b want %b", bus_b.iss_err, exp_err()); end
            if (bus_n.iss_err !== exp_err()) begin n_fail++; $display("FAIL rnd_err_n: got %b want %b", bus_n.iss_err, exp_err()); end
            if (bus_b.busy_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rnd_cnt_b: got %0d want %0d", bus_b.busy_cnt, exp_cnt()); end
            if (bus_n.busy_cnt !== exp_cnt()) begin n_fail++; $display("FAIL rnd_cnt_n: got %0d want %0d", bus_n.busy_cnt, exp_cnt()); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rs1_addr = 0; rs2_addr = 0;
        model_reset();
        #12 rst_n = 1;
        test_reset();
        test_write_x0();
        test_scoreboard();
        test_simul();
        test_waw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised integer register file with write enable, write-to-read bypass and a per-register busy scoreboard for the monkeyV pipelined core. It sits between decode/issue and writeback. It supplies two read operands and flags operands whose producer has issued but not yet written back. It also reports write-after-write issue conflicts and keeps a live count of outstanding writes.

## Interface
Parameters:
- XLEN, 32, data width of every register.
- ADDR_W, 5, register address width; the file holds NREGS = 2**ADDR_W registers.
- SP_IDX, 2, index of the stack-pointer register.
- SP_INIT, 4096, reset value of register SP_IDX.
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to the read ports; 0 = no forwarding.

Ports:
- Clk  in  1  sole clock; all state updates on the rising edge.
- Reset_N  in  1  asynchronous, active-low reset.
- Wr_En  in  1  writeback valid.
- Rd_Addr  in  ADDR_W  writeback destination.
- Rd_Data  in  XLEN  writeback data.
- Rs1_Addr  in  ADDR_W  read port 1 address.
- Rs2_Addr  in  ADDR_W  read port 2 address.
- Rs1_Data  out  XLEN  read port 1 data, combinational.
- Rs2_Data  out  XLEN  read port 2 data, combinational.
- Rs1_Busy  out  1  port 1 operand not yet available.
- Rs2_Busy  out  1  port 2 operand not yet available.
- Iss_En  in  1  an instruction with a destination issues this cycle.
- Iss_Addr  in  ADDR_W  destination of the issuing instruction.
- Iss_Err  out  1  WAW conflict on the current issue, combinational.
- Busy_Cnt  out  ADDR_W+1  number of registers currently marked busy.

## Operation
- Storage: NREGS x XLEN registers plus NREGS busy bits.
- Register 0:
  - Always reads 0.
  - Writes to register 0 are ignored.
  - The busy bit of register 0 is never set.
- Write: when Wr_En=1 and Rd_Addr!=0, the register takes Rd_Data on the edge. The same edge clears busy[Rd_Addr].
- Issue: when Iss_En=1 and Iss_Addr!=0, busy[Iss_Addr] is set on the edge.
- Simultaneous write and issue to the same address: the register takes Rd_Data and busy stays set. The new producer wins.
- Read data for port n (n = 1, 2):
  - Rsn_Addr=0 gives 0.
  - If BYPASS=1, Wr_En=1 and Rd_Addr=Rsn_Addr, the output is Rd_Data.
  - Otherwise the output is the stored value.
- Busy for port n:
  - Rsn_Busy = busy[Rsn_Addr] for a non-zero address.
  - With BYPASS=1 the flag is forced to 0 when a write to that address is present this cycle.
  - With BYPASS=0 the flag stays 1 in the writeback cycle.
- Iss_Err = Iss_En & (Iss_Addr!=0) & busy[Iss_Addr], and is suppressed when a write to Iss_Addr is present this cycle.
  - It is advisory only; the busy bit is still set.
- Busy_Cnt:
  - Registered population count of the busy bits.
  - Updated incrementally each edge by +1 for a new set and -1 for a clear.
  - A set and a clear on the same address in the same cycle is net 0.
  - A set of an already-busy bit is 0.
  - A clear of a non-busy bit is 0.
  - Range is 0..NREGS-1; it never wraps.

## Timing
- Reset (Reset_N=0, asynchronous, takes effect immediately):
  - All registers are 0, except register SP_IDX = SP_INIT.
  - All busy bits are 0 and Busy_Cnt is 0.
  - Rsn_Data therefore reads 0, or SP_INIT when the address is SP_IDX.
  - Rsn_Busy is 0 and Iss_Err is 0.
- Deassertion of Reset_N is synchronised by the system; the block needs no extra release logic.
- Reset asserted in the middle of operation discards all in-flight busy state and data regardless of Wr_En and Iss_En.
- Latency:
  - A write is visible in stored data on the cycle after the edge.
  - With BYPASS=1 it is visible on the read ports in the same cycle.
  - The busy set takes effect on the cycle after the issue edge.
- Rsn_Data, Rsn_Busy and Iss_Err are purely combinational from inputs and state.
- Busy_Cnt is registered and reflects the state after the previous edge.
- Rd_Addr and Iss_Addr out of range cannot occur: ADDR_W fully decodes NREGS.

## Test plan
- Reset:
  - Assert Reset_N=0 mid-clock with prior writes pending.
  - Read address 2 -> 4096; read address 5 -> 0.
  - All busy outputs 0 and Busy_Cnt=0 immediately, without waiting for a clock edge.
- Write and x0:
  - Write 0xDEADBEEF to x7 and to x0.
  - Next cycle: Rs1_Addr=7 -> 0xDEADBEEF; Rs2_Addr=0 -> 0.
  - Issue to x0 -> Busy_Cnt stays 0.
- Scoreboard:
  - Issue x5; next cycle Rs1_Addr=5 -> Rs1_Busy=1, Busy_Cnt=1.
  - Write x5=0x1234 with BYPASS=1 -> Rs1_Busy=0 and Rs1_Data=0x1234 in the same cycle.
  - Busy_Cnt=0 after the edge.
- BYPASS=0 build:
  - Same sequence as the scoreboard scenario.
  - Writeback cycle -> Rs1_Data shows the old value and Rs1_Busy=1.
  - Next cycle -> 0x1234 and busy 0.
- Simultaneous write and issue:
  - x9 busy; write x9=0xAA and issue x9 in the same cycle.
  - Next cycle -> x9 reads 0xAA, Rs1_Busy=1, Busy_Cnt unchanged.
  - Iss_Err=0 during that cycle.
- WAW and count saturation:
  - Issue x3 twice on consecutive cycles -> Iss_Err=1 on the second, Busy_Cnt=1.
  - Issue all 31 non-zero registers -> Busy_Cnt=31.
  - Write all 31 back -> Busy_Cnt=0.
